// File: rtl/knn_insert_sort.sv
`default_nettype none
// ============================================================================
//  Module   : knn_insert_sort
//  Purpose  : Keeps the K smallest (distance, label) samples streamed since the
//             last clear, sorted ascending in registers. slot 0 is the nearest.
//             One insert per cycle, no backpressure. The sorted list is read
//             through a combinational random-access port.
//  Ports    : clk       - clock, rising edge
//             rst       - asynchronous reset, active-low
//             clear     - synchronous list clear (beats in_valid)
//             in_valid  - sample present on dist_in / label_in
//             dist_in   - unsigned squared distance
//             label_in  - label of the training point
//             rd_addr   - slot to read (0 = nearest)
//             rd_dist   - distance in slot rd_addr
//             rd_label  - label in slot rd_addr
//             rd_valid  - slot rd_addr holds a sample
//             count     - occupied slots, saturates at K
//             full      - count == K
//             max_dist  - distance in slot K-1 (all ones while not full)
//  Revision : 1.0 - initial release
// ============================================================================
module knn_insert_sort #(
    parameter int DATA_W  = 16,
    parameter int LABEL_W = 8,
    parameter int K       = 8,
    localparam int DIST_W = 2 * DATA_W,
    localparam int ADDR_W = (K > 1) ? $clog2(K) : 1,
    localparam int CNT_W  = $clog2(K + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [DIST_W-1:0]  dist_in,
    input  logic [LABEL_W-1:0] label_in,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [DIST_W-1:0]  rd_dist,
    output logic [LABEL_W-1:0] rd_label,
    output logic               rd_valid,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic [DIST_W-1:0]  max_dist
);

    localparam logic [CNT_W-1:0]  C_K_CNT   = CNT_W'(K);
    localparam logic [ADDR_W:0]   C_K_ADDR  = (ADDR_W + 1)'(K);
    localparam logic [DIST_W-1:0] C_EMPTY_D = '1;

    // ------------------------------------------------------------------
    // Slot storage
    // ------------------------------------------------------------------
    logic [DIST_W-1:0]  dist_q  [K];
    logic [DIST_W-1:0]  dist_d  [K];
    logic [LABEL_W-1:0] label_q [K];
    logic [LABEL_W-1:0] label_d [K];
    logic [K-1:0]       vld_q;
    logic [K-1:0]       vld_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;

    // w_le[i]  : slot i is occupied and its distance is <= dist_in, so the
    //            new sample must land after it (earlier arrival wins ties).
    //            Because the list is sorted and contiguous this vector is a
    //            thermometer code: ones in slots 0..pos-1.
    // w_prev[i]: w_le of the slot above (slot 0 sees a constant 1).
    // w_wr[i]  : one-hot, slot i is the insertion point.
    // w_sh[i]  : slot i takes the content of slot i-1.
    // If every slot satisfies w_le (pos == K) both vectors are zero and the
    // sample is dropped without any extra logic.
    logic [K-1:0] w_le;
    logic [K-1:0] w_prev;
    logic [K-1:0] w_wr;
    logic [K-1:0] w_sh;

    always_comb begin
        w_le   = '0;
        w_prev = '0;
        w_wr   = '0;
        w_sh   = '0;
        for (int i = 0; i < K; i++) begin
            w_le[i] = vld_q[i] && (dist_q[i] <= dist_in);
        end
        w_prev[0] = 1'b1;
        for (int i = 1; i < K; i++) begin
            w_prev[i] = w_le[i-1];
        end
        for (int i = 0; i < K; i++) begin
            w_wr[i] = !w_le[i] && w_prev[i];
            w_sh[i] = !w_le[i] && !w_prev[i];
        end
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        dist_d  = dist_q;
        label_d = label_q;
        vld_d   = vld_q;
        count_d = count_q;
        if (clear) begin
            for (int i = 0; i < K; i++) begin
                dist_d[i]  = C_EMPTY_D;
                label_d[i] = '0;
            end
            vld_d   = '0;
            count_d = '0;
        end else if (in_valid) begin
            if (w_wr[0]) begin
                dist_d[0]  = dist_in;
                label_d[0] = label_in;
                vld_d[0]   = 1'b1;
            end
            for (int i = 1; i < K; i++) begin
                if (w_wr[i]) begin
                    dist_d[i]  = dist_in;
                    label_d[i] = label_in;
                    vld_d[i]   = 1'b1;
                end else if (w_sh[i]) begin
                    dist_d[i]  = dist_q[i-1];
                    label_d[i] = label_q[i-1];
                    vld_d[i]   = vld_q[i-1];
                end
            end
            // While not full, pos <= count < K, so the sample is always kept.
            if (count_q != C_K_CNT) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < K; i++) begin
                dist_q[i]  <= C_EMPTY_D;
                label_q[i] <= '0;
            end
            vld_q   <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < K; i++) begin
                dist_q[i]  <= dist_d[i];
                label_q[i] <= label_d[i];
            end
            vld_q   <= vld_d;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign count    = count_q;
    assign full     = (count_q == C_K_CNT);
    // Empty slots hold all ones, so the last slot already gives the
    // "all ones while not full" value.
    assign max_dist = dist_q[K-1];

    generate
        if ((1 << ADDR_W) == K) begin : g_rd_pow2
            assign rd_dist  = dist_q[rd_addr];
            assign rd_label = label_q[rd_addr];
            assign rd_valid = vld_q[rd_addr];
        end else begin : g_rd_range
            logic w_in_range;
            assign w_in_range = ({1'b0, rd_addr} < C_K_ADDR);
            assign rd_dist    = w_in_range ? dist_q[rd_addr]  : '0;
            assign rd_label   = w_in_range ? label_q[rd_addr] : '0;
            assign rd_valid   = w_in_range ? vld_q[rd_addr]   : 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire
